// File: rtl/procn.sv
// procn: a small multi-cycle register-file processor.
//
// Each instruction is started by w while idle (T0). {F,Rx,Ry} are then held
// in an instruction register until the instruction finishes. Load, move and
// no-op finish in T1. ALU ops run through three steps:
//   T1: A <= R[Rx]
//   T2: G <= A op R[Ry], and the flags update
//   T3: R[Rx] <= G
// All transfers go over one internal bus, which is built from a multiplexer.
//
// Ports:
//   Clock     rising-edge clock
//   Resetn    synchronous active-low reset
//   w         instruction-start request; only sampled in T0
//   Data      external operand for load; must be held valid through T1
//   F         opcode: 000 load, 001 move, 010 add, 011 sub, 100 and,
//             101 xor, 110/111 no-op
//   Rx, Ry    destination/first operand index, and source operand index
//   BusWires  internal bus value; 0 when no source is selected
//   Done      high during the final step of an instruction
//   Busy      high whenever the step counter is not in T0
//   Zero      last ALU result was 0
//   Carry     add carry-out, sub borrow, 0 for and/xor
//   dbg_step  current step counter (T0..T3), for observation
//
// Handshake: w acts as a request that is accepted only when Busy=0.
// While Busy=1, w is ignored and no back-pressure is applied. Done marks
// the single cycle in which the result is written. w may be asserted again
// in the T0 cycle that directly follows Done.
module procn #(
   parameter int W    = 8,
   parameter int NREG = 4,
   localparam int RW  = $clog2(NREG)
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          w,
   input  logic [W-1:0]  Data,
   input  logic [2:0]    F,
   input  logic [RW-1:0] Rx,
   input  logic [RW-1:0] Ry,
   output logic [W-1:0]  BusWires,
   output logic          Done,
   output logic          Busy,
   output logic          Zero,
   output logic          Carry,
   output logic [1:0]    dbg_step
);

   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_MOVE = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;

   step_t          step;
   logic [2:0]     ir_f;
   logic [RW-1:0]  ir_rx;
   logic [RW-1:0]  ir_ry;
   logic [W-1:0]   regs [NREG];
   logic [W-1:0]   a;
   logic [W-1:0]   g;
   logic [W:0]     alu_full;
   logic [W-1:0]   alu_res;

   function automatic logic is_alu(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_XOR);
   endfunction

   assign dbg_step = step;

   // Bus source multiplexer. T2 and T3 are only reached by ALU ops.
   always_comb begin
      BusWires = '0;
      case (step)
         T1: begin
            case (ir_f)
               OP_LOAD: BusWires = Data;
               OP_MOVE: BusWires = regs[ir_ry];
               OP_ADD, OP_SUB, OP_AND, OP_XOR: BusWires = regs[ir_rx];
               default: BusWires = '0;
            endcase
         end
         T2:      BusWires = regs[ir_ry];
         T3:      BusWires = g;
         default: BusWires = '0;
      endcase
   end

   // The ALU is one bit wider than the data. For sub, the extra bit wraps
   // to 1 exactly when A < operand (unsigned), so it serves as the borrow.
   always_comb begin
      alu_full = '0;
      case (ir_f)
         OP_ADD:  alu_full = {1'b0, a} + {1'b0, BusWires};
         OP_SUB:  alu_full = {1'b0, a} - {1'b0, BusWires};
         OP_AND:  alu_full = {1'b0, a & BusWires};
         OP_XOR:  alu_full = {1'b0, a ^ BusWires};
         default: alu_full = '0;
      endcase
   end
   assign alu_res = alu_full[W-1:0];

   // Step counter, datapath registers and registered Done/Busy.
   // Done and Busy are loaded with their values for the step being entered.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         step  <= T0;
         ir_f  <= '0;
         ir_rx <= '0;
         ir_ry <= '0;
         a     <= '0;
         g     <= '0;
         Zero  <= 1'b0;
         Carry <= 1'b0;
         Done  <= 1'b0;
         Busy  <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         case (step)
            T0: begin
               if (w) begin
                  ir_f  <= F;
                  ir_rx <= Rx;
                  ir_ry <= Ry;
                  step  <= T1;
                  Busy  <= 1'b1;
                  Done  <= !is_alu(F);
               end
            end
            T1: begin
               if (is_alu(ir_f)) begin
                  a    <= BusWires;
                  step <= T2;
               end else begin
                  if (ir_f == OP_LOAD || ir_f == OP_MOVE) regs[ir_rx] <= BusWires;
                  step <= T0;
                  Busy <= 1'b0;
                  Done <= 1'b0;
               end
            end
            T2: begin
               g     <= alu_res;
               Zero  <= (alu_res == '0);
               Carry <= alu_full[W];
               step  <= T3;
               Done  <= 1'b1;
            end
            T3: begin
               regs[ir_rx] <= BusWires;
               step        <= T0;
               Busy        <= 1'b0;
               Done        <= 1'b0;
            end
            default: step <= T0;
         endcase
      end
   end

endmodule

// File: tb/tb_procn.sv
// Bench for procn.
// The main instance (W=8, NREG=4) is checked on every cycle against a
// behavioural model. The model keeps the register contents and flags. Each
// instruction expands into the queue of bus values it must show, one entry
// per busy step. A second instance (W=16, NREG=8) runs a short directed
// sequence.
module tb_procn;
   localparam int W    = 8;
   localparam int NREG = 4;
   localparam int RW   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn;
   logic          w;
   logic [W-1:0]  data;
   logic [2:0]    f;
   logic [RW-1:0] rx, ry;
   logic [W-1:0]  bus_wires;
   logic          done, busy, zero, carry;
   logic [1:0]    dbg_step;

   procn #(.W(W), .NREG(NREG)) dut (
      .Clock(clk), .Resetn(resetn), .w(w), .Data(data), .F(f), .Rx(rx), .Ry(ry),
      .BusWires(bus_wires), .Done(done), .Busy(busy), .Zero(zero), .Carry(carry),
      .dbg_step(dbg_step)
   );

   logic         resetn16, w16;
   logic [15:0]  data16;
   logic [2:0]   f16, rx16, ry16;
   logic [15:0]  bus16;
   logic         done16, busy16, zero16, carry16;
   logic [1:0]   dbg_step16;

   procn #(.W(16), .NREG(8)) dut16 (
      .Clock(clk), .Resetn(resetn16), .w(w16), .Data(data16), .F(f16), .Rx(rx16), .Ry(ry16),
      .BusWires(bus16), .Done(done16), .Busy(busy16), .Zero(zero16), .Carry(carry16),
      .dbg_step(dbg_step16)
   );

   // Model state and per-cycle expectations.
   logic [W-1:0] reg_m [NREG];
   logic [W-1:0] exp_q [$];
   logic [W-1:0] exp_bus;
   logic         exp_done, exp_busy, exp_zero, exp_carry;
   bit           chk_on = 0;
   int           n_checks = 0;
   int           n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   // The compare process runs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("bus",   32'(bus_wires), 32'(exp_bus));
         check("done",  32'(done),      32'(exp_done));
         check("busy",  32'(busy),      32'(exp_busy));
         check("zero",  32'(zero),      32'(exp_zero));
         check("carry", 32'(carry),     32'(exp_carry));
      end
   end

   task automatic set_idle_exp();
      exp_bus  = '0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
   endtask

   // Runs one instruction, starting in T0. When lit is set, the final-step
   // bus value and the flags that follow are also compared against the
   // hand-computed values lv, lz and lc.
   task automatic issue(input logic [2:0] op, input int x, input int y, input logic [W-1:0] d,
                        input bit lit, input logic [W-1:0] lv, input logic lz, input logic lc);
      logic [W-1:0] va, vb, res;
      logic         c_new;
      bit           alu, wr;
      int           s;
      va = reg_m[x]; vb = reg_m[y]; alu = 0; wr = 1; c_new = 1'b0; res = '0;
      exp_q.delete();
      case (op)
         3'd0: begin res = d;  exp_q.push_back(d);  end
         3'd1: begin res = vb; exp_q.push_back(vb); end
         3'd2: begin alu = 1; s = int'(va) + int'(vb); res = W'(s); c_new = (s >= (1 << W)); end
         3'd3: begin alu = 1; res = va - vb; c_new = (va < vb); end
         3'd4: begin alu = 1; res = va & vb; end
         3'd5: begin alu = 1; res = va ^ vb; end
         default: begin wr = 0; exp_q.push_back('0); end
      endcase
      if (alu) begin
         exp_q.push_back(va);
         exp_q.push_back(vb);
         exp_q.push_back(res);
      end
      w = 1'b1; f = op; rx = RW'(x); ry = RW'(y); data = d;
      @(posedge clk); #1;
      for (int i = 0; i < exp_q.size(); i++) begin
         exp_bus  = exp_q[i];
         exp_busy = 1'b1;
         exp_done = (i == exp_q.size() - 1);
         if (alu && i == 2) begin
            exp_zero  = (res == '0);
            exp_carry = c_new;
         end
         // Requests while busy must be ignored.
         w  = 1'($urandom_range(0, 1));
         f  = 3'($urandom_range(0, 7));
         rx = RW'($urandom_range(0, NREG - 1));
         ry = RW'($urandom_range(0, NREG - 1));
         if (lit && i == exp_q.size() - 1) begin
            @(negedge clk);
            check("result_literal", 32'(bus_wires), 32'(lv));
         end
         @(posedge clk); #1;
      end
      if (wr) reg_m[x] = res;
      w = 1'b0;
      set_idle_exp();
      if (lit) begin
         @(negedge clk);
         check("zero_literal",  32'(zero),  32'(lz));
         check("carry_literal", 32'(carry), 32'(lc));
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) reg_m[i] = '0;
      exp_zero  = 1'b0;
      exp_carry = 1'b0;
      set_idle_exp();
   endtask

   // Start an add, then assert reset while it is in T2.
   task automatic reset_in_t2();
      w = 1'b1; f = 3'd2; rx = 2'd0; ry = 2'd1;
      @(posedge clk); #1;
      exp_bus = reg_m[0]; exp_busy = 1'b1; exp_done = 1'b0;
      w = 1'b0;
      @(posedge clk); #1;
      exp_bus = reg_m[1];
      resetn = 1'b0; w = 1'b1; f = 3'd0;
      @(posedge clk); #1;
      model_reset();
      @(posedge clk); #1;
      resetn = 1'b1; w = 1'b0;
   endtask

   // Directed run on the wide instance.
   task automatic op16(input logic [2:0] op, input int x, input int y, input logic [15:0] d,
                       input logic [15:0] lv, input int steps);
      w16 = 1'b1; f16 = op; rx16 = 3'(x); ry16 = 3'(y); data16 = d;
      @(posedge clk); #1;
      w16 = 1'b0;
      repeat (steps - 1) begin @(posedge clk); #1; end
      @(negedge clk);
      check("w16_bus",  32'(bus16),  32'(lv));
      check("w16_done", 32'(done16), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      resetn = 1'b0; w = 1'b0; data = '0; f = '0; rx = '0; ry = '0;
      resetn16 = 1'b0; w16 = 1'b0; data16 = '0; f16 = '0; rx16 = '0; ry16 = '0;
      model_reset();
      @(posedge clk); #1;
      chk_on = 1;
      w = 1'b1;                      // ignored while in reset
      @(posedge clk); #1;
      w = 1'b0; resetn = 1'b1;
      @(posedge clk); #1;

      // load/load/add
      issue(3'd0, 0, 0, 8'h05, 1, 8'h05, 1'b0, 1'b0);
      issue(3'd0, 1, 0, 8'h03, 1, 8'h03, 1'b0, 1'b0);
      issue(3'd2, 0, 1, 8'h00, 1, 8'h08, 1'b0, 1'b0);
      // sub with borrow
      issue(3'd0, 0, 0, 8'h03, 1, 8'h03, 1'b0, 1'b0);
      issue(3'd0, 1, 0, 8'h05, 1, 8'h05, 1'b0, 1'b0);
      issue(3'd3, 0, 1, 8'h00, 1, 8'hFE, 1'b0, 1'b1);
      // add overflowing to zero; the move afterwards keeps the flags
      issue(3'd0, 0, 0, 8'hFF, 1, 8'hFF, 1'b0, 1'b1);
      issue(3'd0, 1, 0, 8'h01, 1, 8'h01, 1'b0, 1'b1);
      issue(3'd2, 0, 1, 8'h00, 1, 8'h00, 1'b1, 1'b1);
      issue(3'd1, 2, 0, 8'h00, 1, 8'h00, 1'b1, 1'b1);
      // Rx = Ry
      issue(3'd2, 1, 1, 8'h00, 1, 8'h02, 1'b0, 1'b0);
      issue(3'd3, 1, 1, 8'h00, 1, 8'h00, 1'b1, 1'b0);
      issue(3'd0, 3, 0, 8'h5A, 1, 8'h5A, 1'b1, 1'b0);
      issue(3'd5, 3, 3, 8'h00, 1, 8'h00, 1'b1, 1'b0);
      // and, then a no-op that leaves the flags untouched
      issue(3'd0, 0, 0, 8'hF0, 1, 8'hF0, 1'b1, 1'b0);
      issue(3'd0, 1, 0, 8'h3C, 1, 8'h3C, 1'b1, 1'b0);
      issue(3'd4, 0, 1, 8'h00, 1, 8'h30, 1'b0, 1'b0);
      issue(3'd6, 2, 3, 8'h00, 1, 8'h00, 1'b0, 1'b0);
      issue(3'd7, 0, 1, 8'h00, 1, 8'h00, 1'b0, 1'b0);
      // Set both flags, load nonzero registers, then reset mid-add.
      issue(3'd0, 0, 0, 8'hFF, 1, 8'hFF, 1'b0, 1'b0);
      issue(3'd0, 1, 0, 8'h01, 1, 8'h01, 1'b0, 1'b0);
      issue(3'd2, 0, 1, 8'h00, 1, 8'h00, 1'b1, 1'b1);
      issue(3'd0, 0, 0, 8'h77, 1, 8'h77, 1'b1, 1'b1);
      reset_in_t2();
      for (int i = 0; i < NREG; i++) issue(3'd1, i, i, 8'h00, 1, 8'h00, 1'b0, 1'b0);

      // Randomized instruction stream.
      for (int i = 0; i < 300; i++) begin
         issue(3'($urandom_range(0, 7)), int'($urandom_range(0, NREG - 1)),
               int'($urandom_range(0, NREG - 1)), W'($urandom_range(0, (1 << W) - 1)),
               0, '0, 1'b0, 1'b0);
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end

      // Wide instance: load, move, xor of equal values.
      @(posedge clk); #1;
      resetn16 = 1'b1;
      op16(3'd0, 7, 0, 16'hABCD, 16'hABCD, 1);
      op16(3'd1, 2, 7, 16'h0000, 16'hABCD, 1);
      op16(3'd5, 2, 7, 16'h0000, 16'h0000, 3);
      @(negedge clk);
      check("w16_zero",  32'(zero16),  32'd1);
      check("w16_carry", 32'(carry16), 32'd0);
      op16(3'd1, 0, 2, 16'h0000, 16'h0000, 1);

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
